noc_link_tx_arbiter: RTL
========================

// Module: noc_link_tx_arbiter
// PURPOSE
// - Shares the TX port of one NoC link PHY (wrreq/header/payload/stall) among NUM_REQ local requesters.
// - Arbitration is round-robin at packet granularity. The grant is held from a packet's first flit until
//   its last flit is accepted, so bursts are never interleaved on the link.
// - Sits between the tile-side NoC sources and the link PHY TX input.
// - A burst-length watchdog and per-requester enable make it the link's TX scheduler/configuration point.
// PARAMETERS
// - NUM_REQ        4    number of requesters, 2..8
// - MAX_BURST_LEN  16   max flits per packet before forced release, 1..255
// - NOC_HEADER_SIZE, NOC_PAYLOAD_SIZE: taken from the shared NoC parameter include
// PORTS
// - clk_i           in   1                     clock
// - rst_i           in   1                     reset; one clock, synchronous, active-high
// - req_en_i        in   NUM_REQ               per-requester enable (static config; 0 = never granted)
// - req_wrreq_i     in   NUM_REQ               requester i presents a valid flit
// - req_last_i      in   NUM_REQ               flit of requester i is the last of its packet
// - req_header_i    in   NUM_REQ*HDR           packed headers, requester i at [i*HDR +: HDR]
// - req_payload_i   in   NUM_REQ*PLD           packed payloads, requester i at [i*PLD +: PLD]
// - req_stall_o     out  NUM_REQ               1 = flit of requester i not accepted this cycle
// - tx_wrreq_o      out  1                     to PHY tx_wrreq
// - tx_header_o     out  HDR                   to PHY tx_header
// - tx_payload_o    out  PLD                   to PHY tx_payload
// - tx_stall_i      in   1                     from PHY tx_stall (FIFO full)
// - grant_o         out  NUM_REQ               one-hot current owner, 0 in IDLE
// - burst_err_o     out  1                     1-cycle pulse on watchdog release
// BEHAVIOUR
// - Transfer rule: flit of requester i is accepted iff req_wrreq_i[i] & grant_o[i] & !tx_stall_i.
// - Requesters hold their flit stable while stalled.
// - Reset values:
//   - FSM = IDLE, grant_o = 0, tx_wrreq_o = 0, tx_header_o = 0, tx_payload_o = 0.
//   - req_stall_o = all 1s, burst_err_o = 0, rr pointer = 0, flit counter = 0.
// - FSM IDLE:
//   - Candidates = req_wrreq_i & req_en_i.
//   - If candidates != 0, register the one-hot grant of the first candidate at or after the rr pointer
//     (wrapping NUM_REQ-1 -> 0), clear the flit counter, and go to BUSY.
//   - All req_stall_o stay 1.
//   - There is one arbitration bubble cycle between packets.
// - FSM BUSY (owner g):
//   - tx_wrreq_o = req_wrreq_i[g], tx_header_o/tx_payload_o = slice g, all combinational.
//   - req_stall_o[g] = tx_stall_i; every other bit is 1.
//   - On accepted flit with req_last_i[g] = 1: go to IDLE, rr pointer <= g+1 (mod NUM_REQ), grant_o <= 0.
//   - On accepted flit with last = 0: counter++.
//   - If counter reaches MAX_BURST_LEN-1 and the next accepted flit is not last:
//     accept it, pulse burst_err_o, release to IDLE and advance the rr pointer.
//   - Owner dropping wrreq mid-packet: the grant is held indefinitely, tx_wrreq_o = 0 and no counter change.
//   - req_en_i[g] falling while BUSY does not revoke the grant; it only affects the next arbitration.
//   - tx_header_o/tx_payload_o are 0 whenever tx_wrreq_o = 0 (no stale data on the link).
// - Single-flit packet (last = 1 on first flit): accepted the cycle after grant, then IDLE.
// - Reset asserted mid-packet: next cycle is IDLE with the reset values; the partial packet is abandoned
//   (the PHY-side flush is the system's concern).
// - Simultaneous requests: RR order is strictly fair; no requester waits more than NUM_REQ-1 packets.
// STRUCTURE
// - Shared NoC package: NOC_HEADER_SIZE and NOC_PAYLOAD_SIZE, plus the FSM state encoding
//   (ARB_IDLE = 1'b0, ARB_BUSY = 1'b1).
// - One sub-module: noc_rr_arbiter (request vector + pointer -> one-hot grant, combinational).
//   It is reusable for the RX side and the router.
// - The datapath mux and the FSM/counter stay in this module.
// TESTING
// - T1 reset/idle: assert rst_i for 3 cycles with random inputs -> grant_o = 0, tx_wrreq_o = 0,
//   req_stall_o = 4'b1111, burst_err_o = 0.
// - T2 RR fairness: all 4 requesters send 1-flit packets continuously, tx_stall_i = 0 -> grant order
//   0,1,2,3,0,...; one accept every 2 cycles; headers match their source.
// - T3 burst atomicity: req0 sends a 5-flit packet and req1 requests at flit 2; tx_stall_i = 1 on
//   cycles 3-4 -> all 5 req0 flits are contiguous on the link with no req1 flit between; req1 is
//   granted only after req0's last flit.
// - T4 watchdog: MAX_BURST_LEN = 4, req2 never asserts last -> 4 flits accepted, burst_err_o pulses
//   once on the 4th, then req3 (pending) is granted.
// - T5 enable mask: req_en_i = 4'b1010 with all requesting -> only 1 and 3 are granted, alternating.
// - T6 reset mid-burst: rst_i after flit 2 of an 8-flit packet -> next cycle IDLE; after release,
//   requester 0 wins (rr pointer = 0).

Source files
------------

// File: rtl/noc_link_tx_arbiter_pkg.sv
// Shared NoC definitions: flit field widths, TX arbiter FSM encoding and a
// one-hot to index helper used by the link arbiters.
package noc_link_tx_arbiter_pkg;

  localparam int NOC_HEADER_SIZE  = 8;
  localparam int NOC_PAYLOAD_SIZE = 32;
  localparam int NOC_MAX_REQ      = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot vector; 0 when the vector is empty.
  function automatic logic [2:0] onehot_to_idx(input logic [NOC_MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NOC_MAX_REQ; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_link_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first active request
// at or after the pointer, wrapping from N-1 back to 0.
module noc_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    int idx;
    grant = '0;
    idx   = 0;
    // Walk offsets from farthest to nearest so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_link_tx_arbiter.sv
// Packet-granular round-robin scheduler sharing one NoC link PHY TX port among
// NUM_REQ requesters, with a burst-length watchdog and per-requester enables.
module noc_link_tx_arbiter
  import noc_link_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST_LEN = 16,
  localparam int HDR = NOC_HEADER_SIZE,
  localparam int PLD = NOC_PAYLOAD_SIZE,
  localparam int PW  = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_en_i,
  input  logic [NUM_REQ-1:0]     req_wrreq_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ*HDR-1:0] req_header_i,
  input  logic [NUM_REQ*PLD-1:0] req_payload_i,
  output logic [NUM_REQ-1:0]     req_stall_o,
  output logic                   tx_wrreq_o,
  output logic [HDR-1:0]         tx_header_o,
  output logic [PLD-1:0]         tx_payload_o,
  input  logic                   tx_stall_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   burst_err_o
);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PW-1:0]      ptr_reg, ptr_next;
  logic [7:0]         cnt_reg, cnt_next;

  logic [NUM_REQ-1:0] candidates;
  logic [NUM_REQ-1:0] arb_grant;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      owner_inc;
  logic               busy;
  logic               owner_wrreq;
  logic               owner_last;
  logic               accept;
  logic               wd_hit;

  assign candidates = req_wrreq_i & req_en_i;

  noc_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req   (candidates),
    .ptr   (ptr_reg),
    .grant (arb_grant)
  );

  assign busy        = (state_reg == ARB_BUSY);
  assign owner       = PW'(onehot_to_idx(NOC_MAX_REQ'(grant_reg)));
  assign owner_inc   = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign owner_wrreq = busy & |(req_wrreq_i & grant_reg);
  assign owner_last  = |(req_last_i & grant_reg);
  assign accept      = owner_wrreq & ~tx_stall_i;
  // Watchdog fires on the flit that would exceed the burst limit without closing the packet.
  assign wd_hit      = accept & ~owner_last & (cnt_reg == 8'(MAX_BURST_LEN - 1));

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    tx_wrreq_o   = owner_wrreq;
    tx_header_o  = '0;
    tx_payload_o = '0;
    req_stall_o  = '1;
    grant_o      = grant_reg;
    burst_err_o  = wd_hit;

    if (owner_wrreq) begin
      tx_header_o  = req_header_i[int'(owner)*HDR +: HDR];
      tx_payload_o = req_payload_i[int'(owner)*PLD +: PLD];
    end

    case (state_reg)
      ARB_IDLE: begin
        if (|candidates) begin
          grant_next = arb_grant;
          cnt_next   = '0;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        req_stall_o = ~grant_reg | {NUM_REQ{tx_stall_i}};
        if (accept) begin
          if (owner_last || wd_hit) begin
            state_next = ARB_IDLE;
            grant_next = '0;
            ptr_next   = owner_inc;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule
